prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 119 +++++++++++
 tb/tb_prog_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed, checksummed byte stream
// from a host, writes it into program memory and releases the CPU once the checksum matches.
module prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       cpu_run,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t     state;
    logic [7:0] len_n;   // byte count; 0 encodes 256
    logic [7:0] idx;
    logic [7:0] sum;
    logic       xfer;

    assign in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    assign xfer     = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order in this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_n    <= 8'h00;
            idx      <= 8'h00;
            sum      <= 8'h00;
            mem_we   <= 1'b0;
            mem_addr <= 8'h00;
            mem_din  <= 8'h00;
            cpu_run  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: mem_we defaults low every cycle so a write is a single-cycle
            // pulse; mem_addr/mem_din have no default and therefore hold.
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LEN;
                        idx   <= 8'h00;
                        sum   <= 8'h00;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        len_n <= in_data;
                        idx   <= 8'h00;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        mem_we   <= 1'b1;
                        mem_addr <= BASE_ADDR + idx;
                        mem_din  <= in_data;
                        sum      <= sum + in_data;
                        idx      <= idx + 8'd1;
                        // len_n == 0 makes the last index 8'hFF, i.e. 256 bytes
                        if (idx == len_n - 8'd1) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        if (in_data == sum) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                            err     <= 1'b0;
                        end else begin
                            state   <= ERR;
                            done    <= 1'b0;
                            cpu_run <= 1'b0;
                            err     <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        state   <= LEN;
                        idx     <= 8'h00;
                        sum     <= 8'h00;
                        cpu_run <= 1'b0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (BASE_ADDR 00 and FE) share one host stream;
// writes are scoreboarded against a queue-based model of the load protocol.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready0, mem_we0, cpu_run0, done0, err0;
    logic [7:0] mem_addr0, mem_din0;
    logic       in_ready1, mem_we1, cpu_run1, done1, err1;
    logic [7:0] mem_addr1, mem_din1;

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_din(mem_din0),
        .cpu_run(cpu_run0), .done(done0), .err(err0)
    );

    prog_loader #(.BASE_ADDR(8'hFE)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1),
        .cpu_run(cpu_run1), .done(done1), .err(err1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wq0[$];
    logic [15:0] wq1[$];
    logic [7:0]  stream_q[$];

    // Write monitor: registered outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (mem_we0) wq0.push_back({mem_addr0, mem_din0});
        if (mem_we1) wq1.push_back({mem_addr1, mem_din1});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // mode 0: back-to-back, 1: one idle cycle before every byte, 2: random idles
    task automatic send_byte(input logic [7:0] b, input int mode);
        int waited;
        int extra;
        waited = 0;
        if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
            if (mode == 2) begin
                extra = $urandom_range(0, 2);
                repeat (extra) @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready0) check("ready_timeout", {31'd0, in_ready0}, 32'd1);
        @(negedge clk);
    endtask

    // Runs one session from stream_q (LEN, data..., CSUM) and scores it against the model.
    task automatic run_load(input string name, input int mode, input logic collide,
                            output logic ok_out);
        int          n;
        logic [7:0]  s;
        logic [15:0] e0[$];
        logic [15:0] e1[$];
        n = (stream_q[0] == 8'h00) ? 256 : int'(stream_q[0]);
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            e0.push_back({8'(i), stream_q[i + 1]});
            e1.push_back({8'(32'hFE + i), stream_q[i + 1]});
            s = s + stream_q[i + 1];
        end
        ok_out = (stream_q[n + 1] == s);

        wq0.delete();
        wq1.delete();
        start = 1'b1;
        if (collide) begin
            in_valid = 1'b1;
            in_data  = 8'h02;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check({name, ":ready_len"}, {31'd0, in_ready0}, 32'd1);
        check({name, ":clr_done"}, {31'd0, done0}, 32'd0);
        check({name, ":clr_err"}, {31'd0, err0}, 32'd0);
        check({name, ":clr_run"}, {31'd0, cpu_run0}, 32'd0);

        foreach (stream_q[i]) send_byte(stream_q[i], mode);
        in_valid = 1'b0;

        check({name, ":done0"}, {31'd0, done0}, {31'd0, ok_out});
        check({name, ":err0"}, {31'd0, err0}, {31'd0, ~ok_out});
        check({name, ":run0"}, {31'd0, cpu_run0}, {31'd0, ok_out});
        check({name, ":done1"}, {31'd0, done1}, {31'd0, ok_out});
        check({name, ":run1"}, {31'd0, cpu_run1}, {31'd0, ok_out});
        check({name, ":ready_end"}, {31'd0, in_ready0}, 32'd0);
        check({name, ":nwr0"}, wq0.size(), e0.size());
        check({name, ":nwr1"}, wq1.size(), e1.size());
        for (int i = 0; i < e0.size(); i++) begin
            if (i < wq0.size()) check({name, ":wr0"}, {16'd0, wq0[i]}, {16'd0, e0[i]});
            if (i < wq1.size()) check({name, ":wr1"}, {16'd0, wq1[i]}, {16'd0, e1[i]});
        end

        repeat (2) @(negedge clk);
        check({name, ":hold_done"}, {31'd0, done0}, {31'd0, ok_out});
        check({name, ":no_late_wr"}, wq0.size(), e0.size());
    endtask

    typedef struct {
        string      name;
        int         len;
        logic [7:0] b [6];
        int         mode;
        logic       exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic ok;
        logic [7:0] s;
        int n;

        vecs[0].name = "basic";    vecs[0].len = 5; vecs[0].mode = 0; vecs[0].exp_done = 1'b1;
        vecs[0].b    = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16, 8'h00};
        vecs[1].name = "mismatch"; vecs[1].len = 4; vecs[1].mode = 0; vecs[1].exp_done = 1'b0;
        vecs[1].b    = '{8'h02, 8'h10, 8'h20, 8'h31, 8'h00, 8'h00};
        vecs[2].name = "wrap";     vecs[2].len = 5; vecs[2].mode = 0; vecs[2].exp_done = 1'b1;
        vecs[2].b    = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h06, 8'h00};
        vecs[3].name = "toggle";   vecs[3].len = 4; vecs[3].mode = 1; vecs[3].exp_done = 1'b1;
        vecs[3].b    = '{8'h02, 8'h55, 8'hAA, 8'hFF, 8'h00, 8'h00};

        // Reset values without any clock edge having been seen yet
        #3;
        check("rst_we", {31'd0, mem_we0}, 32'd0);
        check("rst_addr", {24'd0, mem_addr0}, 32'd0);
        check("rst_din", {24'd0, mem_din0}, 32'd0);
        check("rst_run", {31'd0, cpu_run0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        check("rst_ready", {31'd0, in_ready0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stays in IDLE without start, even with a valid byte offered
        in_valid = 1'b1;
        in_data  = 8'h03;
        repeat (3) @(negedge clk);
        check("idle_ready", {31'd0, in_ready0}, 32'd0);
        check("idle_nowr", wq0.size(), 0);
        in_valid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            stream_q.delete();
            for (int j = 0; j < vecs[v].len; j++) stream_q.push_back(vecs[v].b[j]);
            run_load(vecs[v].name, vecs[v].mode, 1'b0, ok);
            check({vecs[v].name, ":tbl_done"}, {31'd0, done0}, {31'd0, vecs[v].exp_done});
            check({vecs[v].name, ":tbl_err"}, {31'd0, err0}, {31'd0, ~vecs[v].exp_done});
            if (v == 2) begin
                check("wrap_a0", {24'd0, wq1[0][15:8]}, 32'hFE);
                check("wrap_a1", {24'd0, wq1[1][15:8]}, 32'hFF);
                check("wrap_a2", {24'd0, wq1[2][15:8]}, 32'h00);
            end
        end

        // Reload from DONE with N=0: 256 bytes of 01, checksum 00
        stream_q.delete();
        stream_q.push_back(8'h00);
        repeat (256) stream_q.push_back(8'h01);
        stream_q.push_back(8'h00);
        run_load("n256", 0, 1'b0, ok);
        check("n256:done", {31'd0, done0}, 32'd1);

        // Reset mid-load after the 2nd data byte of an N=4 load
        wq0.delete();
        wq1.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_we", {31'd0, mem_we0}, 32'd0);
        check("midrst_addr", {24'd0, mem_addr0}, 32'd0);
        check("midrst_din", {24'd0, mem_din0}, 32'd0);
        check("midrst_ready", {31'd0, in_ready0}, 32'd0);
        check("midrst_run", {31'd0, cpu_run0}, 32'd0);
        check("midrst_addr1", {24'd0, mem_addr1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("midrst_nwr", wq0.size(), 2);
        check("midrst_idle", {31'd0, in_ready0}, 32'd0);

        // Start from IDLE while a byte is offered: the byte must not be taken
        stream_q.delete();
        stream_q.push_back(8'h01);
        stream_q.push_back(8'h7E);
        stream_q.push_back(8'h7E);
        run_load("after_rst", 0, 1'b1, ok);
        check("after_rst:done", {31'd0, done0}, 32'd1);

        // Randomized sessions against the model
        for (int r = 0; r < 12; r++) begin
            stream_q.delete();
            n = $urandom_range(1, 12);
            stream_q.push_back(8'(n));
            s = 8'h00;
            for (int j = 0; j < n; j++) begin
                stream_q.push_back(8'($urandom));
                s = s + stream_q[j + 1];
            end
            if ($urandom_range(0, 1) == 1) stream_q.push_back(s);
            else stream_q.push_back(s ^ 8'($urandom_range(1, 255)));
            run_load("rand", 2, 1'b0, ok);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
